divider_8bit_seq: RTL

//   Iterative unsigned restoring divider, the inverse of the ALU's 8-bit multiplier.

---
 rtl/divider_8bit_seq_pkg.sv | 17 +
 rtl/divider_step.sv | 35 +++
 rtl/divider_8bit_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/divider_8bit_seq_pkg.sv
// -----------------------------------------------------------------------------
// divider_8bit_seq_pkg
//   Shared ALU definitions for the sequential divider: default operand width
//   and the divider FSM state encodings.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package divider_8bit_seq_pkg;

  // Default ALU operand width.
  localparam int DATA_W = 8;

  // Divider FSM state encodings.
  localparam logic [1:0] DIV_S_IDLE = 2'd0;
  localparam logic [1:0] DIV_S_RUN  = 2'd1;
  localparam logic [1:0] DIV_S_DONE = 2'd2;

endpackage : divider_8bit_seq_pkg

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
//   One combinational restoring-division step: shift the next dividend bit
//   into the partial remainder and subtract the divisor if it fits.
//   Ports:
//     i_rem_acc   [WIDTH-1:0]  current partial remainder (always < i_dvsr)
//     i_q_msb                  dividend bit shifted in this step
//     i_dvsr      [WIDTH-1:0]  divisor (non-zero)
//     o_rem_next  [WIDTH-1:0]  partial remainder after this step
//     o_q_bit                  quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step
  import divider_8bit_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] i_rem_acc,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {i_rem_acc, i_q_msb};
  // The shifted remainder is below 2*divisor, so a WIDTH+1 bit difference is
  // exact and its top bit is the sign.
  assign w_diff    = w_shifted - {1'b0, i_dvsr};

  assign o_q_bit    = ~w_diff[WIDTH];
  assign o_rem_next = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule : divider_step

// File: rtl/divider_8bit_seq.sv
// -----------------------------------------------------------------------------
// divider_8bit_seq
//   Iterative unsigned restoring divider, one quotient bit per clock.
//   Accept edge loads the operands; WIDTH iteration edges follow; done pulses
//   for one cycle with quotient/remainder valid. Divide-by-zero completes in
//   one edge with quotient all ones, remainder = dividend, div_by_zero = 1.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     start                     request, sampled only while busy = 0
//     dividend, divisor [W]     operands, sampled on the accepting edge
//     busy                      division in progress
//     done                      one-cycle completion pulse
//     quotient, remainder [W]   results, held until the next completion
//     div_by_zero               divisor was zero, held like quotient
// -----------------------------------------------------------------------------
module divider_8bit_seq
  import divider_8bit_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem_acc;
  logic [WIDTH-1:0] r_q_acc;
  logic [WIDTH-1:0] r_dvsr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem_acc  (r_rem_acc),
    .i_q_msb    (r_q_acc[WIDTH-1]),
    .i_dvsr     (r_dvsr),
    .o_rem_next (w_rem_next),
    .o_q_bit    (w_q_bit)
  );

  // q_acc doubles as the dividend shift register: its MSB feeds the step while
  // the new quotient bit enters at the LSB.
  assign w_q_next = {r_q_acc[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= DIV_S_IDLE;
      r_rem_acc     <= '0;
      r_q_acc       <= '0;
      r_dvsr        <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        DIV_S_RUN: begin
          r_rem_acc <= w_rem_next;
          r_q_acc   <= w_q_next;
          if (r_cnt == '0) begin
            r_quotient    <= w_q_next;
            r_remainder   <= w_rem_next;
            r_div_by_zero <= 1'b0;
            r_state       <= DIV_S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // IDLE and DONE behave identically: DONE only exists to raise done
        // for one cycle while still accepting a new request.
        default: begin
          if (start) begin
            if (divisor != '0) begin
              r_rem_acc <= '0;
              r_q_acc   <= dividend;
              r_dvsr    <= divisor;
              r_cnt     <= CNT_LAST;
              r_state   <= DIV_S_RUN;
            end else begin
              r_quotient    <= '1;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
              r_state       <= DIV_S_DONE;
            end
          end else begin
            r_state <= DIV_S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = (r_state == DIV_S_RUN);
  assign done        = (r_state == DIV_S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule : divider_8bit_seq
